fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_LEN, 16, width of the program counter and instruction-memory word address.
REQ-002 Parameter RESET_PC, 0, first fetch address after reset.
REQ-003 Parameter INSTR_LEN, 32, instruction word width; opcode field is the top OP_CODE_LEN bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 freeze  input  1  stall from the hazard unit; same signal as the decoder's hazard_detected.
REQ-007 branch_taken  input  1  redirect/flush request from execute.
REQ-008 branch_addr  input  PC_LEN  redirect target, sampled when branch_taken=1.
REQ-009 imem_req  output  1  instruction-memory request.
REQ-010 imem_addr  output  PC_LEN  word address of the request; equals the PC register.
REQ-011 imem_ready  input  1  memory accepts and returns data this cycle.
REQ-012 imem_rdata  input  INSTR_LEN  instruction word, valid when imem_req&imem_ready.
REQ-013 instr_out  output  INSTR_LEN  IF/ID instruction register.
REQ-014 pc_out  output  PC_LEN  IF/ID register holding fetch address +1.
REQ-015 valid_out  output  1  IF/ID contents are a live instruction.
REQ-016 opCode  output  OP_CODE_LEN  combinational slice instr_out[INSTR_LEN-1 -: OP_CODE_LEN], forced 0 when valid_out=0.

Function
REQ-017 States: FETCH (request outstanding), STALLED (word captured in one-entry buffer, IF/ID frozen), DISCARD (redirect pending while request outstanding).
REQ-018 imem_req = 1 in FETCH and DISCARD, 0 in STALLED and while rst=1; imem_addr/imem_req remain stable until imem_ready.
REQ-019 FETCH, ready, !freeze, !branch: IF/ID <= {rdata, PC+1, valid=1}; PC <= PC+1; stay FETCH; back-to-back fetch, 1 instr/cycle.
REQ-020 FETCH, !ready, !freeze, !branch: valid_out <= 0 (bubble); PC holds.
REQ-021 FETCH, ready, freeze, !branch: IF/ID holds; rdata and PC+1 into buffer; PC <= PC+1; -> STALLED.
REQ-022 FETCH, !ready, freeze: IF/ID holds; request continues.
REQ-023 STALLED, !freeze, !branch: IF/ID <= buffer, valid=1; -> FETCH.
REQ-024 STALLED, freeze: everything holds.
REQ-025 branch_taken has priority over freeze in every state; valid_out <= 0 at that edge.
REQ-026 Branch in FETCH with ready=1, or in STALLED: returned/buffered word dropped; PC <= branch_addr; -> FETCH.
REQ-027 Branch in FETCH with ready=0: branch_addr into redirect register; -> DISCARD.
REQ-028 DISCARD: returned word dropped; valid_out held 0; further branch_taken overwrites redirect register (latest wins); on ready, PC <= redirect register (or branch_addr if branch_taken same cycle); -> FETCH.
REQ-029 PC+1 wraps modulo 2^PC_LEN (max -> 0), pc_out likewise.

Reset
REQ-030 rst=1 at an edge: PC <= RESET_PC, state <= FETCH, instr_out/pc_out/buffer/redirect <= 0, valid_out <= 0; overrides freeze, branch and any outstanding request (returning data discarded).
REQ-031 First imem_req with imem_addr=RESET_PC in the first cycle rst=0.

Structure
REQ-032 INSTR_LEN, OP_CODE_LEN and the fetch-state enum live in the shared defines/package used by the decoder.
REQ-033 IF/ID register with hold/flush is one sub-module, if_id_reg; FSM, PC, buffer stay in fetch_stage.

Verification
REQ-034 Reset, ready=1 constant, rdata=addr*3 -> imem_addr 0,1,2...; instr_out 0,3,6 one cycle later, pc_out 1,2,3, valid_out=1.
REQ-035 freeze=1 for 3 cycles with ready=1 at addr 5 -> IF/ID holds addr-4 word, buffer holds word5, imem_req=0; after release instr_out=word5, pc_out=6, next fetch addr 6.
REQ-036 ready=0 at addr 8, branch_taken with branch_addr=0x40, ready two cycles later -> word8 never valid, next imem_addr=0x40, valid_out=0 throughout.
REQ-037 freeze=1 and branch_taken=1 same cycle in STALLED, branch_addr=0x20 -> buffer dropped, valid_out=0, next imem_addr=0x20.
REQ-038 PC_LEN=4, fetch from 0xF -> pc_out=0, next imem_addr=0x0.
REQ-039 rst mid-DISCARD with ready arriving same cycle -> valid_out=0, next imem_addr=RESET_PC, no stale word on instr_out.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared instruction-format constants and fetch-state encoding
package fetch_stage_pkg;

  localparam int INSTR_LEN   = 32;
  localparam int OP_CODE_LEN = 6;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    STALLED = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold and flush
module if_id_reg #(
  parameter int PC_LEN    = 16,
  parameter int INSTR_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 flush,
  input  logic [INSTR_LEN-1:0] instr_in,
  input  logic [PC_LEN-1:0]    pc_in,
  output logic [INSTR_LEN-1:0] instr_out,
  output logic [PC_LEN-1:0]    pc_out,
  output logic                 valid_out
);

  // Flush only kills the valid bit; stale contents are masked downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_out <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      valid_out <= 1'b0;
    end else if (load) begin
      instr_out <= instr_in;
      pc_out    <= pc_in;
      valid_out <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch FSM, PC, one-entry stall buffer and IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                PC_LEN    = 16,
  parameter logic [PC_LEN-1:0] RESET_PC  = '0,
  parameter int                INSTR_LEN = fetch_stage_pkg::INSTR_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [PC_LEN-1:0]      branch_addr,
  output logic                   imem_req,
  output logic [PC_LEN-1:0]      imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_LEN-1:0]   imem_rdata,
  output logic [INSTR_LEN-1:0]   instr_out,
  output logic [PC_LEN-1:0]      pc_out,
  output logic                   valid_out,
  output logic [OP_CODE_LEN-1:0] opCode
);

  fetch_state_t          state, state_n;
  logic [PC_LEN-1:0]     pc, pc_n, pc_inc;
  logic [INSTR_LEN-1:0]  buf_instr, buf_instr_n;
  logic [PC_LEN-1:0]     buf_pc, buf_pc_n;
  logic [PC_LEN-1:0]     redirect, redirect_n;
  logic                  ifid_load, ifid_flush;
  logic [INSTR_LEN-1:0]  ifid_instr;
  logic [PC_LEN-1:0]     ifid_pc;

  assign pc_inc    = pc + 1'b1;
  assign imem_addr = pc;
  assign imem_req  = !rst && (state != STALLED);
  assign opCode    = valid_out ? instr_out[INSTR_LEN-1 -: OP_CODE_LEN] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      buf_instr <= '0;
      buf_pc    <= '0;
      redirect  <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      buf_instr <= buf_instr_n;
      buf_pc    <= buf_pc_n;
      redirect  <= redirect_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    buf_instr_n = buf_instr;
    buf_pc_n    = buf_pc;
    redirect_n  = redirect;
    ifid_load   = 1'b0;
    ifid_flush  = 1'b0;
    ifid_instr  = imem_rdata;
    ifid_pc     = pc_inc;
    case (state)
      FETCH: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          if (imem_ready) begin
            pc_n = branch_addr;
          end else begin
            redirect_n = branch_addr;
            state_n    = DISCARD;
          end
        end else if (imem_ready) begin
          pc_n = pc_inc;
          if (freeze) begin
            buf_instr_n = imem_rdata;
            buf_pc_n    = pc_inc;
            state_n     = STALLED;
          end else begin
            ifid_load = 1'b1;
          end
        end else if (!freeze) begin
          ifid_flush = 1'b1;
        end
      end
      STALLED: begin
        // PC already points past the buffered word, so release needs no PC update.
        if (branch_taken) begin
          ifid_flush = 1'b1;
          pc_n       = branch_addr;
          state_n    = FETCH;
        end else if (!freeze) begin
          ifid_load  = 1'b1;
          ifid_instr = buf_instr;
          ifid_pc    = buf_pc;
          state_n    = FETCH;
        end
      end
      DISCARD: begin
        ifid_flush = 1'b1;
        if (branch_taken) redirect_n = branch_addr;
        if (imem_ready) begin
          pc_n    = branch_taken ? branch_addr : redirect;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  if_id_reg #(
    .PC_LEN    (PC_LEN),
    .INSTR_LEN (INSTR_LEN)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .load      (ifid_load),
    .flush     (ifid_flush),
    .instr_in  (ifid_instr),
    .pc_in     (ifid_pc),
    .instr_out (instr_out),
    .pc_out    (pc_out),
    .valid_out (valid_out)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized self-checking bench for fetch_stage
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, freeze, branch_taken, imem_ready;
  logic [15:0] branch_addr;
  logic [31:0] imem_rdata;

  wire                   imem_req, valid_out;
  wire [15:0]            imem_addr, pc_out;
  wire [31:0]            instr_out;
  wire [OP_CODE_LEN-1:0] opCode;

  wire                   req4, valid4;
  wire [3:0]             addr4, pc4;
  wire [31:0]            instr4;
  wire [OP_CODE_LEN-1:0] op4;

  fetch_stage #(.PC_LEN(16), .RESET_PC(16'h0000), .INSTR_LEN(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_out(instr_out),
    .pc_out(pc_out), .valid_out(valid_out), .opCode(opCode)
  );

  fetch_stage #(.PC_LEN(4), .RESET_PC(4'h0), .INSTR_LEN(32)) dut4 (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr[3:0]), .imem_req(req4), .imem_addr(addr4),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_out(instr4),
    .pc_out(pc4), .valid_out(valid4), .opCode(op4)
  );

  typedef struct {
    logic [31:0] instr;
    logic [15:0] pc;
  } ent_t;

  int tests = 0;
  int fails = 0;

  // Reference model: PC, IF/ID contents, a queue of at most one parked word, and an optional pending redirect.
  logic [15:0] m_pc, m_pcout, m_radr;
  logic [31:0] m_instr;
  logic        m_valid, m_rpend;
  ent_t        m_hold[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_pcout = '0; m_instr = '0; m_valid = 1'b0;
    m_rpend = 1'b0; m_radr = '0;
    m_hold.delete();
  endtask

  task automatic model_load(input logic [31:0] ins, input logic [15:0] pcv);
    m_instr = ins; m_pcout = pcv; m_valid = 1'b1;
  endtask

  task automatic step(input logic r, input logic f, input logic b, input logic [15:0] ba,
                      input logic rdy, input logic [31:0] rd);
    ent_t e;
    logic [15:0] nxt;
    logic [5:0]  op_exp;
    rst = r; freeze = f; branch_taken = b; branch_addr = ba; imem_ready = rdy; imem_rdata = rd;
    #1;
    check("imem_req", imem_req, !r && (m_hold.size() == 0));
    if (!r) check("imem_addr", imem_addr, m_pc);
    nxt = m_pc + 16'd1;
    if (r) begin
      model_reset();
    end else if (m_hold.size() != 0) begin
      if (b) begin
        m_hold.delete(); m_valid = 1'b0; m_pc = ba;
      end else if (!f) begin
        e = m_hold.pop_front();
        model_load(e.instr, e.pc);
      end
    end else if (m_rpend) begin
      m_valid = 1'b0;
      if (b) m_radr = ba;
      if (rdy) begin
        m_pc = m_radr; m_rpend = 1'b0;
      end
    end else if (b) begin
      m_valid = 1'b0;
      if (rdy) m_pc = ba;
      else begin
        m_rpend = 1'b1; m_radr = ba;
      end
    end else if (rdy) begin
      if (f) begin
        e.instr = rd; e.pc = nxt;
        m_hold.push_back(e);
      end else begin
        model_load(rd, nxt);
      end
      m_pc = nxt;
    end else if (!f) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("valid_out", valid_out, m_valid);
    if (m_valid) begin
      check("instr_out", instr_out, m_instr);
      check("pc_out", pc_out, m_pcout);
    end
    op_exp = m_valid ? m_instr[31:26] : 6'd0;
    check("opCode", opCode, op_exp);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    model_reset();
    @(negedge clk);

    // Reset, with freeze and branch asserted to show reset overrides them
    step(1, 1, 1, 16'h1234, 1, 32'hFFFF_FFFF);
    step(1, 0, 0, 16'h0000, 0, 32'h0);
    check("rst_valid", valid_out, 0);
    check("rst_instr", instr_out, 0);
    check("rst_pc_out", pc_out, 0);

    // Back-to-back fetch, rdata = addr*3
    for (int k = 0; k < 5; k++) step(0, 0, 0, 16'h0, 1, 32'(m_pc) * 3);
    check("seq_instr", instr_out, 12);
    check("seq_pc_out", pc_out, 5);
    check("seq_addr", imem_addr, 5);

    // Freeze at address 5 for three cycles
    step(0, 1, 0, 16'h0, 1, 32'd15);
    check("frz_hold_instr", instr_out, 12);
    check("frz_hold_pc", pc_out, 5);
    check("frz_req", imem_req, 0);
    step(0, 1, 0, 16'h0, 1, 32'hBAD0_0001);
    step(0, 1, 0, 16'h0, 1, 32'hBAD0_0002);
    check("frz_req2", imem_req, 0);
    step(0, 0, 0, 16'h0, 0, 32'hBAD0_0003);
    check("rel_instr", instr_out, 15);
    check("rel_pc_out", pc_out, 6);
    check("rel_addr", imem_addr, 6);

    // Redirect while request at address 8 is outstanding
    step(0, 0, 0, 16'h0, 1, 32'd18);
    step(0, 0, 0, 16'h0, 1, 32'd21);
    check("pre_disc_addr", imem_addr, 8);
    step(0, 0, 1, 16'h0040, 0, 32'd24);
    check("disc_valid0", valid_out, 0);
    step(0, 0, 0, 16'h0040, 0, 32'd24);
    check("disc_valid1", valid_out, 0);
    step(0, 0, 0, 16'h0040, 1, 32'd24);
    check("disc_valid2", valid_out, 0);
    check("disc_addr", imem_addr, 16'h0040);

    // Branch and freeze together while stalled
    step(0, 1, 0, 16'h0, 1, 32'hC0DE_0040);
    check("stall_req", imem_req, 0);
    step(0, 1, 1, 16'h0020, 0, 32'h0);
    check("brstall_valid", valid_out, 0);
    check("brstall_addr", imem_addr, 16'h0020);
    step(0, 0, 0, 16'h0, 1, 32'hC0DE_0020);
    check("brstall_fetch_pc", pc_out, 16'h0021);
    check("brstall_fetch_instr", instr_out, 32'hC0DE_0020);

    // Reset in the middle of a discard, with data returning on the reset edge
    step(0, 0, 1, 16'h0077, 0, 32'h0);
    step(1, 0, 0, 16'h0, 1, 32'hDEAD_BEEF);
    check("rstdisc_valid", valid_out, 0);
    check("rstdisc_instr", instr_out, 0);
    check("rstdisc_addr", imem_addr, 0);
    step(0, 0, 0, 16'h0, 0, 32'h0);
    check("rstdisc_valid2", valid_out, 0);
    check("rstdisc_req", imem_req, 1);

    // PC wrap on the 4-bit instance
    step(1, 0, 0, 16'h0, 0, 32'h0);
    for (int k = 0; k < 15; k++) step(0, 0, 0, 16'h0, 1, 32'(m_pc) * 3);
    check("wrap_pre_addr", addr4, 4'hF);
    step(0, 0, 0, 16'h0, 1, 32'hA5A5_0F0F);
    check("wrap_pc_out", pc4, 4'h0);
    check("wrap_addr", addr4, 4'h0);
    check("wrap_instr", instr4, 32'hA5A5_0F0F);
    check("wrap_valid", valid4, 1);
    check("wrap_op", op4, 6'h29);
    check("nowrap_pc_out", pc_out, 16'h0010);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(63) == 0, $urandom_range(2) == 0, $urandom_range(7) == 0,
           16'($urandom), $urandom_range(2) != 0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
